// File: rtl/dac_scan_pkg.sv
// Shared types for the DAC scan sequencer: state encoding,
// DAC address split and code/word helpers.
package dac_scan_pkg;

  localparam int DAC_CODE_W = 12;
  localparam int DAC_WORD_W = 16;
  localparam int DAC_ADDR_W = 5;

  localparam logic [DAC_CODE_W-1:0] CODE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_UPDATE,
    ST_WAIT_ACK,
    ST_WAIT_LOAD,
    ST_DWELL,
    ST_NEXT,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [2:0] dev;
    logic [1:0] ch;
  } dac_addr_t;

  function automatic logic [DAC_WORD_W-1:0] code_to_word(
    input logic [DAC_CODE_W-1:0] code
  );
    return {{(DAC_WORD_W-DAC_CODE_W){1'b0}}, code};
  endfunction

  // Ramp step that clips at full scale instead of wrapping.
  function automatic logic [DAC_CODE_W-1:0] sat_add(
    input logic [DAC_CODE_W-1:0] a,
    input logic [DAC_CODE_W-1:0] b
  );
    logic [DAC_CODE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DAC_CODE_W] ? CODE_MAX : s[DAC_CODE_W-1:0];
  endfunction

endpackage

// File: rtl/dac_scan_dwell_timer.sv
// Loadable down-counter: done pulses once the loaded count has
// elapsed while enabled; a zero load is done on the first cycle.
module dac_scan_dwell_timer #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dac_scan_sequencer.sv
// Ramps one DAC word through the serial-DAC controller: write,
// update, wait for the load, dwell, then strobe the readout side.
module dac_scan_sequencer
  import dac_scan_pkg::*;
#(
  parameter int DWELL_W = 24,
  parameter int ACK_TMO = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [4:0]         addr_i,
  input  logic [11:0]        start_val_i,
  input  logic [11:0]        step_i,
  input  logic [11:0]        npoints_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               dac_we_o,
  output logic [4:0]         dac_waddr_o,
  output logic [15:0]        dac_dat_o,
  output logic               update_o,
  input  logic               dac_busy_i,
  output logic               busy_o,
  output logic               point_o,
  output logic [11:0]        cur_val_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);

  state_e             state_q, state_d;
  dac_addr_t          addr_q, addr_d;
  logic [11:0]        cur_val_q, cur_val_d;
  logic [11:0]        step_q, step_d;
  logic [11:0]        pts_left_q, pts_left_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               abort_q, abort_d;
  logic               tmr_load, tmr_en, tmr_done;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cur_val_d  = cur_val_q;
    step_d     = step_q;
    pts_left_d = pts_left_q;
    dwell_d    = dwell_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    err_d      = err_q;
    abort_d    = abort_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    if (state_q != ST_IDLE && abort_i) abort_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d     = addr_i;
          cur_val_d  = start_val_i;
          step_d     = step_i;
          dwell_d    = dwell_i;
          pts_left_d = (npoints_i == '0) ? '0 : npoints_i - 1'b1;
          err_d      = 1'b0;
          abort_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE:  state_d = ST_UPDATE;
      ST_UPDATE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (dac_busy_i) begin
          state_d = ST_WAIT_LOAD;
        end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_LOAD: begin
        if (!dac_busy_i) begin
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
        end
      end
      ST_DWELL: begin
        tmr_en = !abort_q;
        if (abort_q || tmr_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (pts_left_q == '0 || abort_q) begin
          state_d = ST_FINISH;
        end else begin
          pts_left_d = pts_left_q - 1'b1;
          cur_val_d  = sat_add(cur_val_q, step_q);
          state_d    = ST_WRITE;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cur_val_q  <= '0;
      step_q     <= '0;
      pts_left_q <= '0;
      dwell_q    <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cur_val_q  <= cur_val_d;
      step_q     <= step_d;
      pts_left_q <= pts_left_d;
      dwell_q    <= dwell_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  dac_scan_dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .load_i (tmr_load),
    .val_i  (dwell_q),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  assign dac_we_o    = (state_q == ST_WRITE);
  assign update_o    = (state_q == ST_UPDATE);
  assign done_o      = (state_q == ST_FINISH);
  assign point_o     = (state_q == ST_DWELL) && tmr_done;
  assign dac_waddr_o = addr_q;
  assign dac_dat_o   = code_to_word(cur_val_q);
  assign cur_val_o   = cur_val_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Directed bench for dac_scan_sequencer with a behavioural
// serial-DAC controller (busy one cycle after update, LOAD cycles).
module tb_dac_scan_sequencer;

  localparam int DWELL_W = 24;
  localparam int ACK_TMO = 16;
  localparam int LOAD    = 6;

  logic               clk = 1'b0;
  logic               rst_n_i;
  logic               start_i, abort_i;
  logic [4:0]         addr_i;
  logic [11:0]        start_val_i, step_i, npoints_i;
  logic [DWELL_W-1:0] dwell_i;
  logic               dac_we_o, update_o, dac_busy_i;
  logic [4:0]         dac_waddr_o;
  logic [15:0]        dac_dat_o;
  logic               busy_o, point_o, done_o, err_o;
  logic [11:0]        cur_val_o;

  always #5 clk = ~clk;

  dac_scan_sequencer #(
    .DWELL_W(DWELL_W),
    .ACK_TMO(ACK_TMO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .addr_i     (addr_i),
    .start_val_i(start_val_i),
    .step_i     (step_i),
    .npoints_i  (npoints_i),
    .dwell_i    (dwell_i),
    .dac_we_o   (dac_we_o),
    .dac_waddr_o(dac_waddr_o),
    .dac_dat_o  (dac_dat_o),
    .update_o   (update_o),
    .dac_busy_i (dac_busy_i),
    .busy_o     (busy_o),
    .point_o    (point_o),
    .cur_val_o  (cur_val_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // DAC controller model
  logic        ack_en;
  int unsigned ld_cnt = 0;
  logic [15:0] mem [32];

  always @(posedge clk) begin
    if (update_o && ack_en) ld_cnt <= LOAD;
    else if (ld_cnt != 0)   ld_cnt <= ld_cnt - 1;
    if (dac_we_o) mem[dac_waddr_o] <= dac_dat_o;
  end

  assign dac_busy_i = (ld_cnt != 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]         addr;
    logic [11:0]        sv;
    logic [11:0]        step;
    logic [11:0]        np;
    logic [DWELL_W-1:0] dw;
    int                 nexp;
    logic [11:0]        exp [4];
  } vec_t;

  function automatic vec_t mkv(
    input logic [4:0] a, input logic [11:0] sv, input logic [11:0] st,
    input logic [11:0] np, input int dw, input int n,
    input logic [11:0] e0, input logic [11:0] e1,
    input logic [11:0] e2, input logic [11:0] e3);
    vec_t v;
    v.addr = a; v.sv = sv; v.step = st; v.np = np;
    v.dw = DWELL_W'(dw); v.nexp = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  int          r_nwr, r_npt, r_upd, r_badaddr, r_gapbad;
  int          r_upd_cyc, r_done_cyc;
  logic        r_done, r_err, r_err_first;
  logic [11:0] r_codes [16];
  logic [11:0] r_pvals [16];

  task automatic run_scan(input vec_t v, input int abort_upd, input int max_cyc);
    int   fall_cyc;
    logic prev_busy;
    logic aborted;
    @(negedge clk);
    addr_i = v.addr; start_val_i = v.sv; step_i = v.step;
    npoints_i = v.np; dwell_i = v.dw; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    r_nwr = 0; r_npt = 0; r_upd = 0; r_badaddr = 0; r_gapbad = 0;
    r_upd_cyc = -1; r_done_cyc = -1; r_done = 1'b0; r_err = 1'b0;
    r_err_first = err_o;
    fall_cyc = -1; prev_busy = dac_busy_i; aborted = 1'b0;
    for (int c = 0; c < max_cyc && !r_done; c++) begin
      abort_i = 1'b0;
      if (dac_we_o) begin
        if (r_nwr < 16) r_codes[r_nwr] = dac_dat_o[11:0];
        if (dac_waddr_o != v.addr || dac_dat_o[15:12] != 4'h0) r_badaddr++;
        r_nwr++;
      end
      if (update_o) begin
        r_upd++;
        r_upd_cyc = c;
      end
      if (prev_busy && !dac_busy_i) fall_cyc = c;
      if (point_o) begin
        if (r_npt < 16) r_pvals[r_npt] = cur_val_o;
        if (fall_cyc < 0 || c - fall_cyc < int'(v.dw) + 1 ||
            c - fall_cyc > int'(v.dw) + 2) r_gapbad++;
        r_npt++;
      end
      if (done_o) begin
        r_done = 1'b1;
        r_err = err_o;
        r_done_cyc = c;
      end
      if (abort_upd > 0 && !aborted && r_upd == abort_upd && dac_busy_i) begin
        abort_i = 1'b1;
        aborted = 1'b1;
      end
      prev_busy = dac_busy_i;
      @(negedge clk);
    end
    abort_i = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, "_done"}, r_done, 1);
    chk({tag, "_nwr"}, r_nwr, v.nexp);
    chk({tag, "_npt"}, r_npt, v.nexp);
    for (int k = 0; k < v.nexp && k < 4; k++) begin
      chk($sformatf("%s_code%0d", tag, k), r_codes[k], v.exp[k]);
      chk($sformatf("%s_pval%0d", tag, k), r_pvals[k], v.exp[k]);
    end
    chk({tag, "_addr"}, r_badaddr, 0);
    chk({tag, "_gap"}, r_gapbad, 0);
    chk({tag, "_err"}, r_err, 0);
    chk({tag, "_mem"}, mem[v.addr], {4'h0, v.exp[v.nexp-1]});
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  vec_t vt [4];
  vec_t va;
  logic seen_hi, seen_lo;

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; ack_en = 1'b1;
    addr_i = '0; start_val_i = '0; step_i = '0; npoints_i = '0; dwell_i = '0;
    vt[0] = mkv(5'h0A, 12'd100, 12'd50, 12'd4, 10, 4, 12'd100, 12'd150, 12'd200, 12'd250);
    vt[1] = mkv(5'h1F, 12'd4000, 12'd64, 12'd3, 2, 3, 12'd4000, 12'd4064, 12'd4095, 12'd0);
    vt[2] = mkv(5'h03, 12'd7, 12'd1, 12'd0, 0, 1, 12'd7, 12'd0, 12'd0, 12'd0);
    vt[3] = mkv(5'h11, 12'hFF0, 12'h800, 12'd3, 0, 3, 12'hFF0, 12'hFFF, 12'hFFF, 12'd0);

    repeat (3) @(negedge clk);
    chk("reset_outs",
        {dac_we_o, dac_waddr_o, dac_dat_o, update_o, busy_o,
         point_o, cur_val_o, done_o, err_o}, 0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_scan(vt[i], 0, 400);
      @(negedge clk);
      check_vec($sformatf("vec%0d", i), vt[i]);
    end

    // abort during the second point's load
    va = mkv(5'h05, 12'd10, 12'd5, 12'd4, 3, 2, 12'd10, 12'd15, 12'd0, 12'd0);
    run_scan(va, 2, 400);
    @(negedge clk);
    chk("abort_done", r_done, 1);
    chk("abort_nwr", r_nwr, 2);
    chk("abort_npt", r_npt, 1);
    chk("abort_pval0", r_pvals[0], 12'd10);
    chk("abort_err", r_err, 0);
    chk("abort_idle", busy_o, 0);

    // ack timeout
    ack_en = 1'b0;
    run_scan(vt[2], 0, 100);
    @(negedge clk);
    chk("tmo_done", r_done, 1);
    chk("tmo_err_at_done", r_err, 1);
    chk("tmo_latency", r_done_cyc - r_upd_cyc, ACK_TMO + 1);
    chk("tmo_npt", r_npt, 0);
    chk("tmo_idle", busy_o, 0);
    chk("tmo_sticky", err_o, 1);
    ack_en = 1'b1;
    run_scan(vt[2], 0, 400);
    @(negedge clk);
    chk("tmo_clear_first", r_err_first, 0);
    chk("tmo_clear_done", r_err, 0);
    chk("tmo_restart_npt", r_npt, 1);

    // async reset in the middle of a dwell
    @(negedge clk);
    addr_i = 5'h09; start_val_i = 12'd300; step_i = 12'd1;
    npoints_i = 12'd2; dwell_i = 40; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen_hi = 1'b0; seen_lo = 1'b0;
    for (int c = 0; c < 100 && !seen_lo; c++) begin
      if (dac_busy_i) seen_hi = 1'b1;
      else if (seen_hi) seen_lo = 1'b1;
      if (!seen_lo) @(negedge clk);
    end
    chk("rst_reached_dwell", seen_lo, 1);
    repeat (3) @(negedge clk);
    chk("rst_busy_before", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("rst_async_outs",
        {dac_we_o, dac_waddr_o, dac_dat_o, update_o, busy_o,
         point_o, cur_val_o, done_o, err_o}, 0);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    repeat (LOAD) @(negedge clk);
    run_scan(vt[0], 0, 400);
    @(negedge clk);
    check_vec("postrst", vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
